// File: rtl/ofs_plat_prim_uid_tag_remap_if.sv
// Bundle of the request, forward, allocator, response and status signals of the UID tag remapper.
// The master modport is the remapper itself; the slave modport is the surrounding environment.
interface ofs_plat_prim_uid_tag_remap_if #(
  parameter int N_ENTRIES = 32,
  parameter int TAG_BITS  = 8,
  parameter int DATA_BITS = 64
);
  localparam int UID_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);

  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_BITS-1:0]  req_tag;
  logic [DATA_BITS-1:0] req_data;

  logic                 fwd_valid;
  logic                 fwd_ready;
  logic [UID_W-1:0]     fwd_uid;
  logic [DATA_BITS-1:0] fwd_data;

  logic                 uid_alloc;
  logic                 uid_alloc_ready;
  logic [UID_W-1:0]     uid_alloc_uid;
  logic                 uid_free;
  logic [UID_W-1:0]     uid_free_uid;

  logic                 rsp_in_valid;
  logic                 rsp_in_ready;
  logic [UID_W-1:0]     rsp_in_uid;
  logic                 rsp_in_last;
  logic [DATA_BITS-1:0] rsp_in_data;

  logic                 rsp_out_valid;
  logic                 rsp_out_ready;
  logic [TAG_BITS-1:0]  rsp_out_tag;
  logic                 rsp_out_last;
  logic [DATA_BITS-1:0] rsp_out_data;

  logic [CNT_W-1:0]     inflight_cnt;
  logic                 err;

  modport master (
    input  req_valid, req_tag, req_data,
    output req_ready,
    output fwd_valid, fwd_uid, fwd_data,
    input  fwd_ready,
    output uid_alloc,
    input  uid_alloc_ready, uid_alloc_uid,
    output uid_free, uid_free_uid,
    input  rsp_in_valid, rsp_in_uid, rsp_in_last, rsp_in_data,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_tag, rsp_out_last, rsp_out_data,
    input  rsp_out_ready,
    output inflight_cnt, err
  );

  modport slave (
    output req_valid, req_tag, req_data,
    input  req_ready,
    input  fwd_valid, fwd_uid, fwd_data,
    output fwd_ready,
    input  uid_alloc,
    output uid_alloc_ready, uid_alloc_uid,
    input  uid_free, uid_free_uid,
    output rsp_in_valid, rsp_in_uid, rsp_in_last, rsp_in_data,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_tag, rsp_out_last, rsp_out_data,
    output rsp_out_ready,
    input  inflight_cnt, err
  );
endinterface

// File: rtl/ofs_plat_prim_uid_tag_remap.sv
// Swaps client tags for allocator UIDs on requests and restores them on responses, freeing UIDs on last beats.
// Define OFS_PLAT_PRIM_UID_TAG_REMAP_CHECK_EN to add busy-UID tracking and the sticky err flag.
module ofs_plat_prim_uid_tag_remap #(
  parameter int N_ENTRIES = 32,
  parameter int TAG_BITS  = 8,
  parameter int DATA_BITS = 64
) (
  input  logic clk,
  input  logic reset,
  ofs_plat_prim_uid_tag_remap_if.master bus
);
  localparam int UID_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ENTRIES);

  logic                 req_ready_w, req_acc;
  logic                 rsp_in_ready_w, rsp_acc, rsp_fwd;

  logic                 fwd_valid_q;
  logic [UID_W-1:0]     fwd_uid_q;
  logic [DATA_BITS-1:0] fwd_data_q;
  logic [TAG_BITS-1:0]  tag_tbl_q [N_ENTRIES];

  logic                 rsp_valid_q, rsp_last_q;
  logic [TAG_BITS-1:0]  rsp_tag_q;
  logic [DATA_BITS-1:0] rsp_data_q;
  logic                 uid_free_q;
  logic [UID_W-1:0]     uid_free_uid_q;

  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Request path: accept only when a UID is on offer and the forward slot can move.
  assign req_ready_w   = bus.uid_alloc_ready && (!fwd_valid_q || bus.fwd_ready);
  assign req_acc       = bus.req_valid && req_ready_w;
  assign bus.req_ready = req_ready_w;
  assign bus.uid_alloc = req_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
    end else if (req_acc) begin
      fwd_valid_q <= 1'b1;
    end else if (bus.fwd_ready) begin
      fwd_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) begin
      fwd_uid_q                    <= bus.uid_alloc_uid;
      fwd_data_q                   <= bus.req_data;
      tag_tbl_q[bus.uid_alloc_uid] <= bus.req_tag;
    end
  end

  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_uid   = fwd_uid_q;
  assign bus.fwd_data  = fwd_data_q;

  // Response path: table read happens in the accept cycle, before any reallocation can rewrite it.
  assign rsp_in_ready_w   = !rsp_valid_q || bus.rsp_out_ready;
  assign rsp_acc          = bus.rsp_in_valid && rsp_in_ready_w;
  assign bus.rsp_in_ready = rsp_in_ready_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      uid_free_q  <= 1'b0;
    end else begin
      if (rsp_fwd) begin
        rsp_valid_q <= 1'b1;
      end else if (bus.rsp_out_ready) begin
        rsp_valid_q <= 1'b0;
      end
      uid_free_q <= rsp_fwd && bus.rsp_in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fwd) begin
      rsp_tag_q  <= tag_tbl_q[bus.rsp_in_uid];
      rsp_last_q <= bus.rsp_in_last;
      rsp_data_q <= bus.rsp_in_data;
    end
    if (rsp_acc) begin
      uid_free_uid_q <= bus.rsp_in_uid;
    end
  end

  assign bus.rsp_out_valid = rsp_valid_q;
  assign bus.rsp_out_tag   = rsp_tag_q;
  assign bus.rsp_out_last  = rsp_last_q;
  assign bus.rsp_out_data  = rsp_data_q;
  assign bus.uid_free      = uid_free_q;
  assign bus.uid_free_uid  = uid_free_uid_q;

  always_comb begin
    cnt_d = cnt_q;
    if (req_acc && !uid_free_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!req_acc && uid_free_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.inflight_cnt = cnt_q;

`ifdef OFS_PLAT_PRIM_UID_TAG_REMAP_CHECK_EN
  logic [N_ENTRIES-1:0] busy_q, busy_d;
  logic                 err_q;
  logic                 freeing_same, alloc_dup, rsp_stray;

  // A UID whose free is being presented this cycle may legitimately be handed out again.
  assign freeing_same = uid_free_q && (uid_free_uid_q == bus.uid_alloc_uid);
  assign alloc_dup    = req_acc && busy_q[bus.uid_alloc_uid] && !freeing_same;
  assign rsp_stray    = rsp_acc && !busy_q[bus.rsp_in_uid];
  assign rsp_fwd      = rsp_acc && !rsp_stray;

  always_comb begin
    busy_d = busy_q;
    if (uid_free_q) begin
      busy_d[uid_free_uid_q] = 1'b0;
    end
    if (req_acc) begin
      busy_d[bus.uid_alloc_uid] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (alloc_dup || rsp_stray) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign rsp_fwd = rsp_acc;
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/ofs_plat_prim_uid_tag_remap.md
Name: ofs_plat_prim_uid_tag_remap

Overview:
- Request/response tag remapper that sits directly downstream of the UID allocator. It consumes allocated UIDs and returns freed UIDs to it.
- Request path: each accepted request's client tag is stored in a UID-indexed table, and the request is forwarded with the UID in place of the tag.
- Response path: returning responses carry the UID; the block restores the original client tag and frees the UID on the last beat.

Parameters:
N_ENTRIES, 32, UID space size; must match the connected allocator.
TAG_BITS, 8, client tag width.
DATA_BITS, 64, payload width, passed through unmodified on both paths.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  client request valid.
req_ready  out  1  client request accepted when req_valid && req_ready.
req_tag  in  TAG_BITS  client tag.
req_data  in  DATA_BITS  request payload.
fwd_valid  out  1  remapped request valid.
fwd_ready  in  1  downstream ready.
fwd_uid  out  clog2(N_ENTRIES)  UID replacing the tag.
fwd_data  out  DATA_BITS  request payload.
uid_alloc  out  1  consume one UID from the allocator.
uid_alloc_ready  in  1  allocator has a UID.
uid_alloc_uid  in  clog2(N_ENTRIES)  offered UID.
uid_free  out  1  release a UID.
uid_free_uid  out  clog2(N_ENTRIES)  UID being released.
rsp_in_valid  in  1  response beat valid.
rsp_in_ready  out  1  response beat accepted.
rsp_in_uid  in  clog2(N_ENTRIES)  UID of the response.
rsp_in_last  in  1  final beat for this UID.
rsp_in_data  in  DATA_BITS  response payload.
rsp_out_valid  out  1  restored response valid.
rsp_out_ready  in  1  client ready.
rsp_out_tag  out  TAG_BITS  restored client tag.
rsp_out_last  out  1  final beat.
rsp_out_data  out  DATA_BITS  response payload.
inflight_cnt  out  clog2(N_ENTRIES+1)  number of UIDs currently held.
err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: fwd_valid=0, rsp_out_valid=0, uid_free=0, inflight_cnt=0, err=0. Tag table contents are undefined after reset.
- The allocator must share the same reset. A reset mid-operation discards all in-flight requests and responses; no frees are issued for them.
- Request path:
  - req_ready = uid_alloc_ready && (!fwd_valid || fwd_ready).
  - uid_alloc = req_valid && req_ready.
  - On accept: table[uid_alloc_uid] <= req_tag. Next cycle, fwd_valid=1 with fwd_uid=uid_alloc_uid and fwd_data=req_data (1-cycle latency).
  - fwd_valid clears when fwd_ready is high and no new accept occurs. Back-to-back accepts give full throughput.
  - fwd_* outputs hold stable while fwd_valid && !fwd_ready.
- Response path:
  - rsp_in_ready = !rsp_out_valid || rsp_out_ready.
  - On accept: table is read at rsp_in_uid in the accept cycle. Next cycle, rsp_out_valid=1 with rsp_out_tag = table value, and rsp_out_last/rsp_out_data registered (1-cycle latency). Outputs hold while stalled.
  - A last-beat accept drives uid_free=1 and uid_free_uid=rsp_in_uid for exactly one cycle, the cycle after accept. Non-last beats never free.
- Table hazard: none. A UID freed at cycle t+1 cannot be reallocated before t+3 because the allocator registers frees. The table read therefore always precedes any rewrite.
- inflight_cnt:
  - +1 on uid_alloc.
  - -1 on uid_free.
  - Unchanged when both occur in the same cycle.
  - Saturates at N_ENTRIES; never underflows below 0.
- Upstream idle: with uid_alloc_ready=0, req_ready=0 and no table write occurs.

Optional Feature:
- Macro: OFS_PLAT_PRIM_UID_TAG_REMAP_CHECK_EN.
- Enabled:
  - Maintain an N_ENTRIES busy-bit vector: set on alloc, cleared on free; all bits clear on reset.
  - A response accepted for a non-busy UID sets err (sticky until reset). That beat is accepted and dropped: no rsp_out, no uid_free.
  - An alloc of an already-busy UID also sets err.
- Disabled: no busy tracking, err tied to 0, all responses are forwarded.

Test Plan:
- Single request tag=0x5A, allocator offers UID 3 -> uid_alloc pulses 1 cycle; next cycle fwd_uid=3, fwd_data passed; inflight_cnt=1.
- Response UID 3 with last=1 and rsp_out_ready=1 -> next cycle rsp_out_tag=0x5A, uid_free=1 with uid_free_uid=3; inflight_cnt returns to 0.
- Two-beat response for UID 7 (last=0, then last=1) with rsp_out_ready stalled 3 cycles -> outputs held; exactly one uid_free, with uid 7, after the second beat.
- 32 requests with no responses -> inflight_cnt=32; then uid_alloc_ready=0 forces req_ready=0. Then one free and one alloc in the same cycle -> inflight_cnt stays 32.
- fwd_ready=0 with fwd_valid set -> req_ready=0 even though uid_alloc_ready=1; fwd_* unchanged; resumes on fwd_ready=1.
- CHECK_EN built, response for never-allocated UID 9 -> err=1 and stays set; no rsp_out_valid, no uid_free. Reset clears err and inflight_cnt.
